pixel_window_buffer: RTL

//  Parametrised successor to the 3-row pixel input stage of CHIP. Accepts one K-row pixel column per

---
 rtl/pixel_pkg.sv | 20 ++
 rtl/window_shift_reg.sv | 52 +++++
 rtl/pixel_window_buffer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_pkg: shared defaults, state encoding and pad-mode constants
// Rev 1.0
// ----------------------------------------------------------------------------
package pixel_pkg;

  localparam int PIX_W_DEF = 5;
  localparam int K_DEF     = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  localparam logic PAD_ZERO = 1'b0;
  localparam logic PAD_REPL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/window_shift_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// window_shift_reg: K-column window shift register with border-pad preload
// Rev 1.0
// ----------------------------------------------------------------------------
module window_shift_reg
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int K     = K_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 preload_i,
  input  logic                 shift_i,
  input  logic                 mode_i,
  input  logic [K*PIX_W-1:0]   col_i,
  output logic [K*K*PIX_W-1:0] win_o
);

  localparam int COL_W = K*PIX_W;

  logic [K*COL_W-1:0] win_q, win_d;
  logic [COL_W-1:0]   pad_col;

  // Preload fills every older slot with the pad; slots beyond HALF are shifted
  // out before the window is ever declared valid.
  always_comb begin
    pad_col = (mode_i == PAD_REPL) ? col_i : '0;
    win_d   = win_q;
    if (preload_i) begin
      for (int c = 0; c < K-1; c++) begin
        win_d[c*COL_W +: COL_W] = pad_col;
      end
      win_d[(K-1)*COL_W +: COL_W] = col_i;
    end else if (shift_i) begin
      win_d = {col_i, win_q[K*COL_W-1:COL_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule
`default_nettype wire

// File: rtl/pixel_window_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_window_buffer: column-in, KxK-window-out stage with zero/replicate padding
// Rev 1.0
// ----------------------------------------------------------------------------
module pixel_window_buffer
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int K     = K_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 col_valid,
  output logic                 col_ready,
  input  logic [K*PIX_W-1:0]   col_data,
  input  logic                 load_end,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [K*K*PIX_W-1:0] win_data,
  output logic                 line_done
);

  localparam int HALF    = (K-1)/2;
  localparam int COL_W   = K*PIX_W;
  localparam int FILL_W  = $clog2(K+1);
  localparam int FLUSH_W = $clog2(HALF+1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(K);
  localparam logic [FILL_W-1:0]  FILL_START = FILL_W'(HALF+1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(HALF);

  logic [1:0]         state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic               mode_q, mode_d;
  logic               win_valid_q, win_valid_d;
  logic               line_done_q, line_done_d;

  logic               out_free;
  logic               col_acc;
  logic               preload;
  logic               flush_shift;
  logic               shift;
  logic [COL_W-1:0]   newest_col;
  logic [COL_W-1:0]   shift_col;

  // During flush the newest slot is the last real column or a copy of it.
  assign newest_col = win_data[(K-1)*COL_W +: COL_W];

  always_comb begin
    out_free    = !win_valid_q || win_ready;
    col_ready   = reset && (state_q != ST_FLUSH) && out_free;
    col_acc     = col_valid && col_ready;
    preload     = col_acc && (state_q == ST_IDLE);
    flush_shift = (state_q == ST_FLUSH) && (flush_cnt_q != FLUSH_LAST) && out_free;
    shift       = (col_acc && (state_q != ST_IDLE)) || flush_shift;
    shift_col   = col_data;
    if (flush_shift) begin
      shift_col = (mode_q == PAD_ZERO) ? '0 : newest_col;
    end

    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mode_d      = mode_q;
    win_valid_d = win_valid_q;
    line_done_d = 1'b0;

    if (preload) begin
      fill_cnt_d = FILL_START;
    end else if (shift && (fill_cnt_q != FILL_FULL)) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end

    if (preload || shift) begin
      win_valid_d = (fill_cnt_d == FILL_FULL);
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (preload) begin
          mode_d      = mode;
          flush_cnt_d = '0;
          state_d     = load_end ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (col_acc) begin
          if (load_end) begin
            state_d = ST_FLUSH;
          end else if (fill_cnt_d == FILL_FULL) begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (col_acc && load_end) begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        if (flush_shift) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end else if ((flush_cnt_q == FLUSH_LAST) && win_valid_q && win_ready) begin
          line_done_d = 1'b1;
          fill_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      flush_cnt_q <= '0;
      mode_q      <= PAD_ZERO;
      win_valid_q <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mode_q      <= mode_d;
      win_valid_q <= win_valid_d;
      line_done_q <= line_done_d;
    end
  end

  window_shift_reg #(
    .PIX_W (PIX_W),
    .K     (K)
  ) u_window_shift_reg (
    .clk       (clk),
    .rst_n     (reset),
    .preload_i (preload),
    .shift_i   (shift),
    .mode_i    (mode),
    .col_i     (shift_col),
    .win_o     (win_data)
  );

  assign win_valid = win_valid_q;
  assign line_done = line_done_q;

endmodule
`default_nettype wire
